// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker
//   Receive-only PS/2 mouse front end. It deserialises 11-bit PS/2 frames,
//   assembles 3-byte stream-mode packets and integrates the deltas into an
//   absolute cursor position. The position is clamped to the screen and
//   presented as pixel << FRAC.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 lines
//   x_mouse, y_mouse    cursor position, pixel << FRAC (y = 0 is top)
//   left_btn, right_btn button state from the last accepted packet
//   pos_valid           one-cycle pulse when position/buttons update
//   frame_err           one-cycle pulse on parity/framing error or timeout
module mouse_position_tracker #(
  parameter int width          = 32,
  parameter int FRAC           = 12,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [width-1:0] x_mouse,
  output logic [width-1:0] y_mouse,
  output logic             left_btn,
  output logic             right_btn,
  output logic             pos_valid,
  output logic             frame_err
);

  localparam int PW = 16;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [PW-1:0] X_MAX_S = PW'(X_MAX);
  localparam logic signed [PW-1:0] Y_MAX_S = PW'(Y_MAX);

  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, UPDATE} pkt_state_e;

  pkt_state_e state_q, state_d;

  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          dat_s1_q, dat_s2_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [5:0]    flags_q, flags_d;   // {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [7:0]    dx_lo_q, dx_lo_d, dy_lo_q, dy_lo_d;
  logic [PW-1:0] x_pix_q, x_pix_d, y_pix_q, y_pix_d;
  logic          left_q, left_d, right_q, right_d;
  logic          pos_valid_q, pos_valid_d, frame_err_q, frame_err_d;

  logic fall, byte_stb, bad_frame, timeout, err;
  logic ld_flags, ld_x, ld_y, do_update;
  logic signed [PW-1:0] dx, dy, x_sum, y_sum;

  assign fall = clk_s3_q & ~clk_s2_q;

  // Frame receiver and idle timeout. frame_q shifts LSB-first so after ten
  // edges bit 0 holds the start bit, [8:1] the data and [9] the parity; the
  // stop bit is taken straight from the synchronised line at edge ten.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    to_cnt_d  = '0;
    byte_stb  = 1'b0;
    bad_frame = 1'b0;
    timeout   = 1'b0;
    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (!frame_q[0] && dat_s2_q && (^frame_q[9:1])) byte_stb  = 1'b1;
        else                                            bad_frame = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        frame_d   = {dat_s2_q, frame_q[9:1]};
      end
    end else if (bit_cnt_q != '0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout   = 1'b1;
        bit_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  assign err = bad_frame | timeout;

  // Packet FSM: next state
  always_comb begin
    state_d = state_q;
    if (err) begin
      state_d = BYTE0;
    end else begin
      case (state_q)
        BYTE0:   if (byte_stb && frame_q[4]) state_d = BYTE1;
        BYTE1:   if (byte_stb) state_d = BYTE2;
        BYTE2:   if (byte_stb) state_d = UPDATE;
        UPDATE:  state_d = BYTE0;
        default: state_d = BYTE0;
      endcase
    end
  end

  // Packet FSM: outputs (frame_q[4] is bit 3 of the received byte)
  always_comb begin
    ld_flags  = (state_q == BYTE0) && byte_stb && frame_q[4];
    ld_x      = (state_q == BYTE1) && byte_stb;
    ld_y      = (state_q == BYTE2) && byte_stb;
    do_update = (state_q == UPDATE);
  end

  // Datapath: capture packet bytes, integrate and clamp the position.
  always_comb begin
    flags_d     = flags_q;
    dx_lo_d     = dx_lo_q;
    dy_lo_d     = dy_lo_q;
    x_pix_d     = x_pix_q;
    y_pix_d     = y_pix_q;
    left_d      = left_q;
    right_d     = right_q;
    pos_valid_d = do_update;
    frame_err_d = err;

    if (ld_flags) flags_d = {frame_q[8], frame_q[7], frame_q[6], frame_q[5],
                             frame_q[2], frame_q[1]};
    if (ld_x) dx_lo_d = frame_q[8:1];
    if (ld_y) dy_lo_d = frame_q[8:1];

    dx = flags_q[4] ? '0 : {{(PW-8){flags_q[2]}}, dx_lo_q};
    dy = flags_q[5] ? '0 : {{(PW-8){flags_q[3]}}, dy_lo_q};
    // PS/2 reports up as positive while screen y grows downwards.
    x_sum = $signed(x_pix_q) + dx;
    y_sum = $signed(y_pix_q) - dy;

    if (do_update) begin
      if (x_sum < 0)            x_pix_d = '0;
      else if (x_sum > X_MAX_S) x_pix_d = X_MAX_S;
      else                      x_pix_d = x_sum;
      if (y_sum < 0)            y_pix_d = '0;
      else if (y_sum > Y_MAX_S) y_pix_d = Y_MAX_S;
      else                      y_pix_d = y_sum;
      left_d  = flags_q[0];
      right_d = flags_q[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_s3_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= BYTE0;
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      to_cnt_q    <= '0;
      flags_q     <= '0;
      dx_lo_q     <= '0;
      dy_lo_q     <= '0;
      x_pix_q     <= PW'(X_INIT);
      y_pix_q     <= PW'(Y_INIT);
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      pos_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      clk_s3_q    <= clk_s2_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      to_cnt_q    <= to_cnt_d;
      flags_q     <= flags_d;
      dx_lo_q     <= dx_lo_d;
      dy_lo_q     <= dy_lo_d;
      x_pix_q     <= x_pix_d;
      y_pix_q     <= y_pix_d;
      left_q      <= left_d;
      right_q     <= right_d;
      pos_valid_q <= pos_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign x_mouse   = width'(x_pix_q) << FRAC;
  assign y_mouse   = width'(y_pix_q) << FRAC;
  assign left_btn  = left_q;
  assign right_btn = right_q;
  assign pos_valid = pos_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mouse_position_tracker.sv
module tb_mouse_position_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] x_mouse, y_mouse;
  logic        left_btn, right_btn, pos_valid, frame_err;

  mouse_position_tracker #(.width(32), .FRAC(12), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .x_mouse(x_mouse), .y_mouse(y_mouse), .left_btn(left_btn),
    .right_btn(right_btn), .pos_valid(pos_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pv_cnt = 0, fe_cnt = 0;
  int exp_pv = 0, exp_fe = 0;

  // reference model: integer pixel position and a queue of accepted bytes
  int m_x = 320, m_y = 240;
  bit m_l = 0, m_r = 0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] b0, b1, b2;
    int x, y;
    bit l, r;
  } vec_t;
  vec_t vecs[15];

  // pulse counting, overlap and output stability monitor
  logic [31:0] px, py;
  logic pl, pr, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (pos_valid && frame_err) begin
      bad++;
      $display("FAIL overlap: pos_valid=%b frame_err=%b required not both", pos_valid, frame_err);
    end
    if (rst_n && prev_rst && !pos_valid &&
        (x_mouse != px || y_mouse != py || left_btn != pl || right_btn != pr)) begin
      bad++;
      $display("FAIL stable: x=%h y=%h changed from x=%h y=%h without pos_valid",
               x_mouse, y_mouse, px, py);
    end
    px = x_mouse; py = y_mouse; pl = left_btn; pr = right_btn;
    prev_rst = rst_n;
    if (pos_valid) pv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  task automatic model_apply();
    int dx, dy;
    dx = q[0][6] ? 0 : (q[0][4] ? int'(q[1]) - 256 : int'(q[1]));
    dy = q[0][7] ? 0 : (q[0][5] ? int'(q[2]) - 256 : int'(q[2]));
    m_x = clampi(m_x + dx, 639);
    m_y = clampi(m_y - dy, 479);
    m_l = q[0][0];
    m_r = q[0][1];
    exp_pv++;
    q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit badp);
    if (badp) begin
      q.delete();
      exp_fe++;
    end else if (q.size() != 0 || b[3]) begin
      q.push_back(b);
      if (q.size() == 3) model_apply();
    end
  endtask

  // drive nbits of an 11-bit frame; badp flips the parity bit
  task automatic send_frame(input logic [7:0] b, input bit badp, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ badp, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cycles(8);
      ps2_clk = 1'b0;
      cycles(16);
      ps2_clk = 1'b1;
      cycles(8);
    end
    ps2_data = 1'b1;
    cycles(8);
  endtask

  task automatic xfer(input logic [7:0] b, input bit badp);
    send_frame(b, badp, 11);
    model_byte(b, badp);
  endtask

  task automatic check_all(input string nm);
    @(negedge clk);
    chk({nm, "_x"}, x_mouse, 32'(m_x) << 12);
    chk({nm, "_y"}, y_mouse, 32'(m_y) << 12);
    chk({nm, "_l"}, 32'(left_btn), 32'(m_l));
    chk({nm, "_r"}, 32'(right_btn), 32'(m_r));
    chk({nm, "_pv"}, pv_cnt, exp_pv);
    chk({nm, "_fe"}, fe_cnt, exp_fe);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cycles(3);
    @(negedge clk);
    chk("rst_x", x_mouse, 32'h0014_0000);
    chk("rst_y", y_mouse, 32'h000F_0000);
    chk("rst_btn", {30'd0, left_btn, right_btn}, 32'd0);
    chk("rst_strb", {30'd0, pos_valid, frame_err}, 32'd0);
    m_x = 320; m_y = 240; m_l = 0; m_r = 0;
    q.delete();
    rst_n = 1'b1;
    cycles(5);
  endtask

  initial begin
    vecs[0]  = '{8'h09, 8'h05, 8'h00, 325, 240, 1, 0};
    vecs[1]  = '{8'h28, 8'h00, 8'hF6, 325, 250, 0, 0};
    vecs[2]  = '{8'h18, 8'h00, 8'h00,  69, 250, 0, 0};
    vecs[3]  = '{8'h18, 8'h00, 8'h00,   0, 250, 0, 0};
    vecs[4]  = '{8'h18, 8'h00, 8'h00,   0, 250, 0, 0};
    vecs[5]  = '{8'h0A, 8'h7F, 8'h7F, 127, 123, 0, 1};
    vecs[6]  = '{8'h08, 8'hFF, 8'h00, 382, 123, 0, 0};
    vecs[7]  = '{8'h48, 8'h50, 8'h00, 382, 123, 0, 0};
    vecs[8]  = '{8'h08, 8'h00, 8'h7F, 382,   0, 0, 0};
    vecs[9]  = '{8'h28, 8'h00, 8'h01, 382, 255, 0, 0};
    vecs[10] = '{8'hA8, 8'h00, 8'h80, 382, 255, 0, 0};
    vecs[11] = '{8'h08, 8'hFF, 8'h00, 637, 255, 0, 0};
    vecs[12] = '{8'h08, 8'hFF, 8'h00, 639, 255, 0, 0};
    vecs[13] = '{8'h0B, 8'h00, 8'h00, 639, 255, 1, 1};
    vecs[14] = '{8'h28, 8'h00, 8'h00, 639, 479, 0, 0};

    // reset and idle lines: no pulses
    do_reset();
    cycles(1000);
    check_all("idle");

    // directed table
    foreach (vecs[i]) begin
      xfer(vecs[i].b0, 0);
      xfer(vecs[i].b1, 0);
      xfer(vecs[i].b2, 0);
      @(negedge clk);
      chk("tbl_x", x_mouse, 32'(vecs[i].x) << 12);
      chk("tbl_y", y_mouse, 32'(vecs[i].y) << 12);
      chk("tbl_btn", {30'd0, left_btn, right_btn}, {30'd0, vecs[i].l, vecs[i].r});
      check_all("tbl");
    end

    // x clamp at 0 from reset: 64, 0, 0
    do_reset();
    xfer(8'h18, 0); xfer(8'h00, 0); xfer(8'h00, 0);
    @(negedge clk); chk("clamp1", x_mouse, 32'h0004_0000);
    xfer(8'h18, 0); xfer(8'h00, 0); xfer(8'h00, 0);
    @(negedge clk); chk("clamp2", x_mouse, 32'h0);
    xfer(8'h18, 0); xfer(8'h00, 0); xfer(8'h00, 0);
    check_all("clamp3");

    // bad parity on byte1 aborts the packet
    do_reset();
    xfer(8'h08, 0);
    xfer(8'h01, 1);
    check_all("par_err");
    xfer(8'h08, 0); xfer(8'h01, 0); xfer(8'h00, 0);
    @(negedge clk); chk("par_next_x", x_mouse, 32'(321) << 12);
    check_all("par_next");

    // leading byte without sync bit discarded
    xfer(8'h00, 0);
    xfer(8'h08, 0); xfer(8'h02, 0); xfer(8'h00, 0);
    @(negedge clk); chk("sync_x", x_mouse, 32'(323) << 12);
    check_all("sync");

    // truncated frame -> timeout after 100 idle cycles
    xfer(8'h08, 0);
    send_frame(8'h05, 0, 4);
    cycles(52);
    @(negedge clk); chk("to_early", fe_cnt, exp_fe);
    cycles(60);
    q.delete(); exp_fe++;
    check_all("timeout");
    xfer(8'h08, 0); xfer(8'h03, 0); xfer(8'h00, 0);
    @(negedge clk); chk("to_next_x", x_mouse, 32'(326) << 12);
    check_all("to_next");

    // reset mid-packet and mid-frame discards everything
    xfer(8'h09, 0);
    xfer(8'h10, 0);
    send_frame(8'h33, 0, 5);
    do_reset();
    xfer(8'h08, 0); xfer(8'h04, 0); xfer(8'h00, 0);
    @(negedge clk); chk("rst_mid_x", x_mouse, 32'(324) << 12);
    check_all("rst_mid");

    // randomized frames against the model
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      bit bp;
      b = 8'($urandom);
      if (q.size() == 0 && $urandom_range(0, 1) == 1) b[3] = 1'b1;
      bp = ($urandom_range(0, 9) == 0);
      xfer(b, bp);
      check_all("rnd");
    end

    cycles(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
